// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial sequence detector: state encoding and
// default pattern/counter widths.
package seq_det_pkg;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    HIT   = 2'b10
  } state_e;

endpackage

// File: rtl/seq_window.sv
// History shift register and saturating fill counter for the sequence detector.
// full_eq reports that the post-shift window is full and equals the pattern.
module seq_window
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             in,
  input  logic [PAT_W-1:0] pattern,
  output logic             full_eq
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist_q, hist_d, hist_shift;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;

  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], in};
    fill_inc   = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
    // Compare against the shifted window so the match is seen on the edge
    // that samples the final bit; independent of clear to avoid a loop.
    full_eq    = shift_en && (fill_inc == FILL_W'(PAT_W)) && (hist_shift == pattern);

    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector with Moore detect pulse.
// Define SEQDET_MATCH_COUNT_EN to build the saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic [PAT_W-1:0] pattern,
  input  logic             pat_load,
  input  logic             overlap,
  output logic             out,
  output logic             armed,
  output logic [CNT_W-1:0] match_count
);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             win_shift, win_clear, win_full_eq, load_ok;

  // A pending pat_load suppresses the shift so it wins over a simultaneous match.
  assign win_shift = in_valid && !pat_load && (state_q == ARMED || state_q == HIT);

  seq_window #(
    .PAT_W(PAT_W)
  ) u_window (
    .clk     (clk),
    .reset   (reset),
    .shift_en(win_shift),
    .clear   (win_clear),
    .in      (in),
    .pattern (pat_q),
    .full_eq (win_full_eq)
  );

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    win_clear = 1'b0;
    load_ok   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pat_load) begin
          load_ok = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED, HIT: begin
        if (pat_load) begin
          load_ok = 1'b1;
          state_d = ARMED;
        end else if (win_full_eq) begin
          state_d   = HIT;
          win_clear = !overlap;
        end else begin
          state_d = ARMED;
        end
      end
      default: begin
        state_d   = IDLE;
        win_clear = 1'b1;
      end
    endcase
    if (load_ok) begin
      pat_d     = pattern;
      win_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
    end
  end

  assign out   = (state_q == HIT);
  assign armed = (state_q == ARMED) || (state_q == HIT);

`ifdef SEQDET_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // state_d == HIT only on a genuine match entry (a load always goes to ARMED).
  always_comb begin
    cnt_d = cnt_q;
    if (load_ok) begin
      cnt_d = '0;
    end else if (state_d == HIT && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: three instances (PAT_W 3, 4, 2/CNT_W 2)
// share the serial stream; per-instance monitors pop expected pulses.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset, in_b, in_valid, overlap;
  logic [2:0] pattern3;
  logic [3:0] pattern4;
  logic [1:0] pattern2;
  logic       ld3, ld4, ld2;
  logic       out3, out4, out2, armed3, armed4, armed2;
  logic [7:0] cnt3, cnt4;
  logic [1:0] cnt2;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t q3[$], q4[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_detector_param #(.PAT_W(3), .CNT_W(8)) u_dut3 (
    .clk(clk), .reset(reset), .in(in_b), .in_valid(in_valid), .pattern(pattern3),
    .pat_load(ld3), .overlap(overlap), .out(out3), .armed(armed3), .match_count(cnt3));

  seq_detector_param #(.PAT_W(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .reset(reset), .in(in_b), .in_valid(in_valid), .pattern(pattern4),
    .pat_load(ld4), .overlap(overlap), .out(out4), .armed(armed4), .match_count(cnt4));

  seq_detector_param #(.PAT_W(2), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .in(in_b), .in_valid(in_valid), .pattern(pattern2),
    .pat_load(ld2), .overlap(overlap), .out(out2), .armed(armed2), .match_count(cnt2));

  function automatic int expc(int n, int sat);
`ifdef SEQDET_MATCH_COUNT_EN
    return (n > sat) ? sat : n;
`else
    return 0;
`endif
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every observed pulse must match the oldest expected pulse.
  always @(negedge clk) begin
    exp_t e;
    if (out3 !== 1'b0) begin
      $display("dut3 pulse cyc=%0d cnt=%0d", cyc, cnt3);
      check("dut3 pulse expected", q3.size() > 0, 1);
      if (q3.size() > 0) begin
        e = q3.pop_front();
        check("dut3 pulse cycle", cyc, e.cyc);
        check("dut3 pulse count", cnt3, e.cnt);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (out4 !== 1'b0) begin
      $display("dut4 pulse cyc=%0d cnt=%0d", cyc, cnt4);
      check("dut4 pulse expected", q4.size() > 0, 1);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        check("dut4 pulse cycle", cyc, e.cyc);
        check("dut4 pulse count", cnt4, e.cnt);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (out2 !== 1'b0) begin
      $display("dut2 pulse cyc=%0d cnt=%0d", cyc, cnt2);
      check("dut2 pulse expected", q2.size() > 0, 1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check("dut2 pulse cycle", cyc, e.cyc);
        check("dut2 pulse count", cnt2, e.cnt);
      end
    end
  end

  // Drive one bit at a negedge; if hit, a pulse is expected one cycle later.
  task automatic bit_tx(int d, logic b, logic v, bit hit, int c);
    exp_t e;
    in_b     = b;
    in_valid = v;
    if (hit) begin
      e.cyc = cyc + 1;
      e.cnt = c;
      case (d)
        2:       q2.push_back(e);
        3:       q3.push_back(e);
        default: q4.push_back(e);
      endcase
    end
    @(negedge clk);
  endtask

  task automatic load(int d, logic [3:0] p);
    in_valid = 1'b0;
    case (d)
      2:       begin pattern2 = p[1:0]; ld2 = 1'b1; end
      3:       begin pattern3 = p[2:0]; ld3 = 1'b1; end
      default: begin pattern4 = p;      ld4 = 1'b1; end
    endcase
    @(negedge clk);
    ld2 = 1'b0;
    ld3 = 1'b0;
    ld4 = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) bit_tx(0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    reset = 1'b1; in_b = 1'b0; in_valid = 1'b0; overlap = 1'b1;
    pattern3 = '0; pattern4 = '0; pattern2 = '0;
    ld3 = 1'b0; ld4 = 1'b0; ld2 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset out3", out3, 0);
    check("reset armed3", armed3, 0);
    check("reset cnt3", cnt3, 0);
    check("reset armed4", armed4, 0);
    check("reset armed2", armed2, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle armed3 before load", armed3, 0);

    // PAT 101, overlap on, stream 10101: pulses after bits 3 and 5
    overlap = 1'b1;
    load(3, 4'b0101);
    check("armed3 after load", armed3, 1);
    bit_tx(3, 1, 1, 0, 0);
    bit_tx(3, 0, 1, 0, 0);
    bit_tx(3, 1, 1, 1, expc(1, 255));
    check("armed3 during hit", armed3, 1);
    bit_tx(3, 0, 1, 0, 0);
    bit_tx(3, 1, 1, 1, expc(2, 255));
    idle(2);
    check("overlap cnt3", cnt3, expc(2, 255));
    check("overlap q3 drained", q3.size(), 0);

    // Same stream, overlap off: only the first match
    do_reset();
    overlap = 1'b0;
    load(3, 4'b0101);
    bit_tx(3, 1, 1, 0, 0);
    bit_tx(3, 0, 1, 0, 0);
    bit_tx(3, 1, 1, 1, expc(1, 255));
    bit_tx(3, 0, 1, 0, 0);
    bit_tx(3, 1, 1, 0, 0);
    idle(2);
    check("no-overlap cnt3", cnt3, expc(1, 255));
    check("no-overlap q3 drained", q3.size(), 0);

    // Asynchronous reset during the 4th bit of 1011 discards progress
    do_reset();
    overlap = 1'b1;
    load(4, 4'b1011);
    bit_tx(4, 1, 1, 0, 0);
    bit_tx(4, 0, 1, 0, 0);
    bit_tx(4, 1, 1, 0, 0);
    in_b = 1'b1;
    in_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("async reset armed4", armed4, 0);
    check("async reset out4", out4, 0);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("armed4 after reset", armed4, 0);
    load(4, 4'b1011);
    bit_tx(4, 1, 1, 0, 0);
    bit_tx(4, 1, 1, 0, 0);
    bit_tx(4, 0, 1, 0, 0);
    bit_tx(4, 1, 1, 0, 0);
    bit_tx(4, 1, 1, 1, expc(1, 255));
    idle(2);
    check("reset test cnt4", cnt4, expc(1, 255));
    check("reset test q4 drained", q4.size(), 0);

    // PAT 110 with invalid cycles; a shifted invalid 0 would fake an early match
    do_reset();
    load(3, 4'b0110);
    bit_tx(3, 1, 1, 0, 0);
    bit_tx(3, 0, 0, 0, 0);
    bit_tx(3, 1, 0, 0, 0);
    bit_tx(3, 1, 1, 0, 0);
    bit_tx(3, 0, 0, 0, 0);
    bit_tx(3, 1, 0, 0, 0);
    bit_tx(3, 0, 1, 1, expc(1, 255));
    bit_tx(3, 1, 0, 0, 0);
    bit_tx(3, 0, 0, 0, 0);
    idle(1);
    check("in_valid cnt3", cnt3, expc(1, 255));
    check("in_valid q3 drained", q3.size(), 0);

    // PAT 11, CNT_W 2: consecutive pulses, saturation, load beats a match
    do_reset();
    overlap = 1'b1;
    load(2, 4'b0011);
    bit_tx(2, 1, 1, 0, 0);
    for (int i = 1; i <= 5; i++) bit_tx(2, 1, 1, 1, expc(i, 3));
    check("saturated cnt2", cnt2, expc(5, 3));
    pattern2 = 2'b11;
    ld2 = 1'b1;
    bit_tx(2, 1, 1, 0, 0);
    ld2 = 1'b0;
    check("cnt2 cleared by load", cnt2, 0);
    check("armed2 after reload", armed2, 1);
    bit_tx(2, 1, 1, 0, 0);
    bit_tx(2, 1, 1, 1, expc(1, 3));
    idle(2);
    check("reload cnt2", cnt2, expc(1, 3));
    check("q2 drained", q2.size(), 0);

    check("final q3 drained", q3.size(), 0);
    check("final q4 drained", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
